// File: rtl/lfsr_pkg.sv
// lfsr_pkg: default tap masks per width, default seed, and the FILL/HOLD sample FSM encoding
package lfsr_pkg;
  localparam logic [31:0] TAPS_4 = 32'h0000_000C;
  localparam logic [31:0] TAPS_8 = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] TAPS_32 = 32'h8000_0062;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;
  typedef enum logic {FILL, HOLD} fsm_e;
  function automatic logic [31:0] default_taps(input int w);
    return w == 4 ? TAPS_4 : w == 8 ? TAPS_8 : w == 16 ? TAPS_16 : TAPS_32;
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register (clk, w_rst, step_i, load_i, seed_i -> state_o, fb_o); a zero seed loads SEED instead
module lfsr_core import lfsr_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [31:0] TAPS = TAPS_32,
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             w_rst,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic             fb_o
);
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  logic [WIDTH-1:0] state_q, state_d;
  assign fb_o = ^(state_q & TAPS_W);
  assign state_o = state_q;
  always_comb state_d = load_i ? (seed_i == '0 ? SEED_W : seed_i) : step_i ? {state_q[WIDTH-2:0], fb_o} : state_q;
  always_ff @(posedge clk) state_q <= w_rst ? SEED_W : state_d;
endmodule

// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: LFSR sample generator (clk, w_rst, i_en, i_random, i_flag_width, i_load, i_seed, i_ready -> o_valid, o_sample, o_state)
module lfsr_prng_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [31:0] TAPS = TAPS_32,
  parameter logic [31:0] SEED = DEFAULT_SEED,
  parameter int OUT_BITS = 4,
  parameter int FIXED_A = 4,
  parameter int FIXED_B = 3
) (
  input  logic                clk,
  input  logic                w_rst,
  input  logic                i_en,
  input  logic                i_random,
  input  logic                i_flag_width,
  input  logic                i_load,
  input  logic [WIDTH-1:0]    i_seed,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [OUT_BITS-1:0] o_sample,
  output logic [WIDTH-1:0]    o_state
);
  localparam int CW = OUT_BITS > 1 ? $clog2(OUT_BITS) : 1;
  fsm_e fsm_q;
  logic [CW-1:0] cnt_q;
  logic [OUT_BITS-1:0] sample_q, sample_d, fixed_d;
  logic valid_q, fb, step, last;
  assign step = fsm_q == FILL && i_random && i_en;
  assign last = cnt_q == CW'(OUT_BITS - 1);
  assign o_valid = valid_q;
  assign o_sample = sample_q;
  always_comb begin
    sample_d = OUT_BITS'({sample_q, fb});
    fixed_d = i_flag_width ? OUT_BITS'(FIXED_A) : OUT_BITS'(FIXED_B);
  end
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk(clk), .w_rst(w_rst), .step_i(step), .load_i(i_load), .seed_i(i_seed), .state_o(o_state), .fb_o(fb)
  );
  always_ff @(posedge clk) begin
    if (w_rst || i_load) begin
      fsm_q <= FILL;
      cnt_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
    end else if (fsm_q == FILL) begin
      if (!i_random) begin
        sample_q <= fixed_d;
        valid_q <= 1'b1;
        cnt_q <= '0;
        fsm_q <= HOLD;
      end else if (i_en) begin
        sample_q <= sample_d;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
        if (last) begin
          valid_q <= 1'b1;
          fsm_q <= HOLD;
        end
      end
    end else if (i_ready) begin
      valid_q <= 1'b0;
      fsm_q <= FILL;
    end
  end
endmodule

// File: doc/lfsr_prng_gen.md
Name: lfsr_prng_gen

Overview:
- Parametrised Fibonacci-LFSR pseudo-random sample generator.
- Replaces the fixed 4-bit and 32-bit LFSR blocks: configurable width and taps, runtime seed load, lock-up protection, and a valid/ready sample output.
- Random mode: assembles OUT_BITS fresh feedback bits into each sample.
- Fixed mode: emits one of two constant values, as the game-logic consumers need.

Parameters:
- WIDTH, 32, LFSR state width (4..32).
- TAPS, 32'h8000_0062, feedback tap mask; bit i set = state[i] included in the XOR; only bits [WIDTH-1:0] used.
- SEED, 32'hFFFF_FFFF, reset and fallback seed; low WIDTH bits used; must be non-zero.
- OUT_BITS, 4, sample width (1..WIDTH).
- FIXED_A, 4, fixed-mode value when i_flag_width=1.
- FIXED_B, 3, fixed-mode value when i_flag_width=0.

Ports:
- clk  in  1  clock
- w_rst  in  1  reset
- i_en  in  1  allow LFSR stepping while filling
- i_random  in  1  1 = random mode, 0 = fixed mode
- i_flag_width  in  1  fixed-value select
- i_load  in  1  load seed
- i_seed  in  WIDTH  seed value for i_load
- i_ready  in  1  consumer accepts sample
- o_valid  out  1  sample valid
- o_sample  out  OUT_BITS  sample data
- o_state  out  WIDTH  current LFSR state

Behaviour:
- Clock and reset: clock clk. Reset w_rst, synchronous, active-high.
- Reset values: state = SEED[WIDTH-1:0], o_sample = 0, o_valid = 0, bit counter = 0, FSM = FILL.
- Priority per edge: w_rst > i_load > FSM operation.
- Step rule:
  - fb = XOR-reduce(state & TAPS[WIDTH-1:0]).
  - state_next = {state[WIDTH-2:0], fb}.
  - sample_next = {sample[OUT_BITS-2:0], fb}; for OUT_BITS=1, sample_next = fb.
- FSM has two states, FILL and HOLD.
- FILL, i_random=1, i_en=1:
  - Step once per cycle, cnt++.
  - On the step with cnt == OUT_BITS-1: cnt <= 0, o_valid <= 1, go to HOLD.
  - Latency: first sample is valid OUT_BITS cycles after the first enabled FILL edge.
- FILL, i_random=1, i_en=0: no step; state, cnt and sample hold.
- FILL, i_random=0:
  - Next edge: o_sample <= (i_flag_width ? FIXED_A : FIXED_B) truncated to OUT_BITS, o_valid <= 1, cnt <= 0, go to HOLD.
  - LFSR does not step; i_en is ignored.
- Mode select (i_random, i_flag_width) is sampled only in FILL. Changes during HOLD take effect on the next sample.
- HOLD:
  - LFSR frozen; o_sample and o_valid stable until handshake.
  - Handshake (o_valid & i_ready): o_valid <= 0, go to FILL. No step occurs in the handshake cycle.
  - Max throughput is one random sample per OUT_BITS+1 cycles.
- i_load, any state:
  - state <= (i_seed == 0) ? SEED : i_seed.
  - cnt <= 0, o_valid <= 0, o_sample <= 0, go to FILL.
  - A partially filled sample is discarded.
  - If o_valid & i_ready in the load cycle, the transfer counts as completed; the consumer has taken the value present.
- Lock-up guard: all-zero state is unreachable. Seed-0 substitution covers load; reset uses the non-zero SEED.
- o_state is always the registered LFSR state.
- w_rst mid-fill or mid-hold: abandon everything and restore the reset values.

Decomposition:
- Shared package lfsr_pkg holds:
  - Default tap masks per width: 4 -> 4'hC, 8 -> 8'hB8, 16 -> 16'hD008, 32 -> 32'h8000_0062.
  - DEFAULT_SEED.
  - FSM state encoding {FILL, HOLD}.
- One natural sub-module, lfsr_core: WIDTH/TAPS/SEED, step/load inputs, state and fb outputs. The sample FSM lives in lfsr_prng_gen.

Test Plan:
- Reset sequence, defaults, i_random=1, i_en=1, i_ready=0, 4 edges after reset:
  - Fb bits 0,0,1,1; states FFFFFFFE, FFFFFFFC, FFFFFFF9, FFFFFFF3.
  - o_valid=1, o_sample=4'h3, o_state=32'hFFFF_FFF3, then both held while i_ready=0 for 10 cycles.
- Handshake: assert i_ready one cycle with o_valid=1 -> o_valid=0 next cycle, FSM in FILL, o_state unchanged that cycle, next sample valid 4 edges later.
- Fixed mode: i_random=0, i_flag_width=1 -> after 1 edge o_valid=1, o_sample=4; after handshake with i_flag_width=0 -> o_sample=3; o_state never changes.
- Seed load:
  - i_load=1, i_seed=0 mid-fill (cnt=2) -> o_state=FFFF_FFFF, o_valid=0, cnt restarts; the first sample again equals 4'h3.
  - i_seed=32'h1 -> o_state=1.
- i_en gating: drop i_en for 5 cycles mid-fill -> o_state and cnt frozen; sample completes exactly 4 enabled edges in total.
- Period check (WIDTH=4, TAPS=4'hC, SEED=4'h1, OUT_BITS=1) -> o_state visits 15 distinct non-zero values before repeating, never 0.
